// File: rtl/audio_clk_pkg.sv
// audio_clk_pkg
// Shared definitions for the audio clock generator: the controller state
// enumeration and the default values of the top-level parameters.
package audio_clk_pkg;

    // Controller states. IDLE holds every channel cleared, SETTLE lets the
    // channels run while the lock counter times out, RUN reports lock.
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_RUN    = 2'd2
    } state_t;

    localparam int              ACC_W_DEF       = 32;
    // 12.288 MHz from a 50 MHz reference with a 32-bit accumulator.
    localparam longint unsigned RESET_INCR_DEF  = 64'd1055531162;
    localparam int              LOCK_CYCLES_DEF = 1024;

endpackage

// File: rtl/audio_nco_channel.sv
// audio_nco_channel
// One numerically controlled oscillator channel: phase accumulator, active
// increment, pending increment and the glitch-free commit logic.
//
// Ports
//   refclk     in   reference clock, rising edge
//   rst        in   asynchronous active-high reset
//   run        in   accumulate this cycle; low clears acc and outputs
//   load       in   accept load_incr as the new pending increment
//   load_incr  in   increment value to make pending
//   commit     out  pending increment is copied to incr at this edge
//   pend_flag  out  a pending increment is waiting to be committed
//   outclk     out  registered MSB of the accumulator
//   outclk_stb out  one-cycle pulse on each outclk rising edge
module audio_nco_channel
    import audio_clk_pkg::*;
#(
    parameter int               ACC_W      = ACC_W_DEF,
    parameter logic [ACC_W-1:0] RESET_INCR = '0
) (
    input  logic             refclk,
    input  logic             rst,
    input  logic             run,
    input  logic             load,
    input  logic [ACC_W-1:0] load_incr,
    output logic             commit,
    output logic             pend_flag,
    output logic             outclk,
    output logic             outclk_stb
);

    logic [ACC_W-1:0] acc;
    logic [ACC_W-1:0] incr;
    logic [ACC_W-1:0] pending;
    logic [ACC_W:0]   sum;
    logic             carry;

    // The extra sum bit is the carry out of the accumulator; a new increment
    // is only swapped in on that wrap so no output period is ever cut short.
    // When stopped, or when the current increment is zero, no carry can
    // happen, so the pending value is taken straight away instead.
    always_comb begin
        sum    = {1'b0, acc} + {1'b0, incr};
        carry  = sum[ACC_W];
        commit = pend_flag && (!run || (incr == '0) || carry);
    end

    // Accumulator and output registers. outclk always equals the MSB of the
    // stored accumulator, so comparing the new MSB with outclk yields the
    // rising-edge strobe.
    always_ff @(posedge refclk or posedge rst) begin
        if (rst) begin
            acc        <= '0;
            outclk     <= 1'b0;
            outclk_stb <= 1'b0;
        end else if (run) begin
            acc        <= sum[ACC_W-1:0];
            outclk     <= sum[ACC_W-1];
            outclk_stb <= sum[ACC_W-1] & ~outclk;
        end else begin
            acc        <= '0;
            outclk     <= 1'b0;
            outclk_stb <= 1'b0;
        end
    end

    // Increment bookkeeping. A load in the same cycle as a commit wins the
    // flag, so the committed value is the old pending one and the new value
    // waits for the next opportunity.
    always_ff @(posedge refclk or posedge rst) begin
        if (rst) begin
            incr      <= RESET_INCR;
            pending   <= '0;
            pend_flag <= 1'b0;
        end else begin
            if (commit) begin
                incr      <= pending;
                pend_flag <= 1'b0;
            end
            if (load) begin
                pending   <= load_incr;
                pend_flag <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/audio_clk_gen.sv
// audio_clk_gen
// Multi-channel audio clock generator. Each channel is a phase-accumulator
// NCO; this level owns the run/settle/lock controller, the lock counter and
// the configuration handshake.
//
// Ports
//   refclk     in   sole clock, rising edge
//   rst        in   asynchronous active-high reset
//   enable     in   run request; low stops all channels
//   cfg_valid  in   configuration request
//   cfg_ready  out  configuration can be accepted (no update pending)
//   cfg_sel    in   target channel index; out-of-range writes are dropped
//   cfg_incr   in   new phase increment
//   outclk     out  registered square-wave clocks, one per channel
//   outclk_stb out  one-cycle pulse on each outclk rising edge
//   locked     out  all channels running with stable configuration
module audio_clk_gen
    import audio_clk_pkg::*;
#(
    parameter int              NUM_CLOCKS  = 2,
    parameter int              ACC_W       = ACC_W_DEF,
    parameter longint unsigned RESET_INCR  = RESET_INCR_DEF,
    parameter int              LOCK_CYCLES = LOCK_CYCLES_DEF
) (
    input  logic                  refclk,
    input  logic                  rst,
    input  logic                  enable,
    input  logic                  cfg_valid,
    output logic                  cfg_ready,
    input  logic [2:0]            cfg_sel,
    input  logic [ACC_W-1:0]      cfg_incr,
    output logic [NUM_CLOCKS-1:0] outclk,
    output logic [NUM_CLOCKS-1:0] outclk_stb,
    output logic                  locked
);

    localparam int                CNT_W    = (LOCK_CYCLES > 1) ? $clog2(LOCK_CYCLES) : 1;
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(LOCK_CYCLES - 1);

    state_t                  state;
    state_t                  state_next;
    logic [CNT_W-1:0]        lock_cnt;
    logic [CNT_W-1:0]        cnt_next;
    logic [NUM_CLOCKS-1:0]   commit;
    logic [NUM_CLOCKS-1:0]   pend_flag;
    logic [NUM_CLOCKS-1:0]   load;
    logic                    xfer;
    logic                    run;
    logic                    any_commit;

    // Channels accumulate only while the controller is active and enable is
    // still high; dropping enable clears them at the same edge the controller
    // falls back to IDLE, so outclk is low from the very next cycle.
    always_comb begin
        cfg_ready  = ~|pend_flag;
        xfer       = cfg_valid && cfg_ready;
        run        = enable && (state != ST_IDLE);
        any_commit = |commit;
        locked     = (state == ST_RUN);
    end

    // Address decode for the handshake. A select beyond the last channel
    // matches nothing, so such a write completes but leaves no trace.
    always_comb begin
        load = '0;
        for (int i = 0; i < NUM_CLOCKS; i++) begin
            load[i] = xfer && (cfg_sel == 3'(i));
        end
    end

    generate
        for (genvar i = 0; i < NUM_CLOCKS; i++) begin : g_ch
            audio_nco_channel #(
                .ACC_W      (ACC_W),
                .RESET_INCR (ACC_W'(RESET_INCR))
            ) u_ch (
                .refclk     (refclk),
                .rst        (rst),
                .run        (run),
                .load       (load[i]),
                .load_incr  (cfg_incr),
                .commit     (commit[i]),
                .pend_flag  (pend_flag[i]),
                .outclk     (outclk[i]),
                .outclk_stb (outclk_stb[i])
            );
        end
    endgenerate

    // State and lock counter registers.
    always_ff @(posedge refclk or posedge rst) begin
        if (rst) begin
            state    <= ST_IDLE;
            lock_cnt <= '0;
        end else begin
            state    <= state_next;
            lock_cnt <= cnt_next;
        end
    end

    // Controller next-state. Enable low overrides everything. Any increment
    // change while active restarts the settle window, because the new
    // frequency has not yet been stable for LOCK_CYCLES cycles.
    always_comb begin
        state_next = state;
        cnt_next   = lock_cnt;
        if (!enable) begin
            state_next = ST_IDLE;
            cnt_next   = '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    state_next = ST_SETTLE;
                    cnt_next   = '0;
                end
                ST_SETTLE: begin
                    if (any_commit) begin
                        cnt_next = '0;
                    end else if (lock_cnt == CNT_LAST) begin
                        state_next = ST_RUN;
                        cnt_next   = '0;
                    end else begin
                        cnt_next = lock_cnt + CNT_W'(1);
                    end
                end
                ST_RUN: begin
                    if (any_commit) begin
                        state_next = ST_SETTLE;
                        cnt_next   = '0;
                    end
                end
                default: begin
                    state_next = ST_IDLE;
                    cnt_next   = '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_audio_clk_gen.sv
// tb_audio_clk_gen
// Bench for audio_clk_gen with two channels, an 8-bit accumulator, a lock
// time of four cycles and a reset increment of 64 (period four).
module tb_audio_clk_gen;

    localparam int NCLK = 2;
    localparam int AW   = 8;
    localparam int LOCK = 4;
    localparam int RINC = 64;
    localparam int MODV = 2 ** AW;
    localparam int HALF = 2 ** (AW - 1);

    logic            refclk = 1'b0;
    logic            rst;
    logic            enable;
    logic            cfg_valid;
    logic            cfg_ready;
    logic [2:0]      cfg_sel;
    logic [AW-1:0]   cfg_incr;
    logic [NCLK-1:0] outclk;
    logic [NCLK-1:0] outclk_stb;
    logic            locked;

    always #5 refclk = ~refclk;

    audio_clk_gen #(
        .NUM_CLOCKS  (NCLK),
        .ACC_W       (AW),
        .RESET_INCR  (RINC),
        .LOCK_CYCLES (LOCK)
    ) dut (
        .refclk     (refclk),
        .rst        (rst),
        .enable     (enable),
        .cfg_valid  (cfg_valid),
        .cfg_ready  (cfg_ready),
        .cfg_sel    (cfg_sel),
        .cfg_incr   (cfg_incr),
        .outclk     (outclk),
        .outclk_stb (outclk_stb),
        .locked     (locked)
    );

    typedef struct packed {
        logic [NCLK-1:0] clk;
        logic [NCLK-1:0] stb;
        logic            lck;
        logic            rdy;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_pass   = 0;

    // Reference model state: phase and step as plain integers, a wait flag
    // plus value for each pending update, and a countdown of cycles left
    // before lock is reported.
    int   m_phase   [NCLK];
    int   m_step    [NCLK];
    int   m_pend    [NCLK];
    bit   m_wait    [NCLK];
    bit   m_prev    [NCLK];
    bit   m_running;
    int   m_settle;
    bit   m_ready;
    bit   m_xfer;
    bit   m_active;
    bit   m_commit;
    bit   m_any_commit;
    bit   m_out;
    int   m_new;
    exp_t m_e;

    task automatic check_val(input string name, input logic [7:0] act, input logic [7:0] req);
        n_checks++;
        if (act !== req) begin
            $display("[TB] FAIL %s at %0t: got %h, expected %h", name, $time, act, req);
        end else begin
            n_pass++;
        end
    endtask

    // Behavioural model, advanced on every reference edge from the inputs
    // that were applied before that edge.
    always @(posedge refclk or posedge rst) begin
        if (rst) begin
            for (int c = 0; c < NCLK; c++) begin
                m_phase[c] = 0;
                m_step[c]  = RINC;
                m_pend[c]  = 0;
                m_wait[c]  = 1'b0;
                m_prev[c]  = 1'b0;
            end
            m_running = 1'b0;
            m_settle  = 0;
            exp_q.delete();
        end else begin
            m_ready = 1'b1;
            for (int c = 0; c < NCLK; c++) if (m_wait[c]) m_ready = 1'b0;
            m_xfer       = cfg_valid && m_ready;
            m_active     = m_running && enable;
            m_any_commit = 1'b0;
            m_e          = '0;
            for (int c = 0; c < NCLK; c++) begin
                m_commit = m_wait[c] &&
                           (!m_active || m_step[c] == 0 || m_phase[c] + m_step[c] >= MODV);
                m_new    = m_active ? (m_phase[c] + m_step[c]) % MODV : 0;
                m_out    = (m_new >= HALF);
                m_e.clk[c] = m_out;
                m_e.stb[c] = m_out && !m_prev[c];
                m_prev[c]  = m_out;
                m_phase[c] = m_new;
                if (m_commit) begin
                    m_step[c]    = m_pend[c];
                    m_wait[c]    = 1'b0;
                    m_any_commit = 1'b1;
                end
                if (m_xfer && int'(cfg_sel) == c) begin
                    m_pend[c] = int'(cfg_incr);
                    m_wait[c] = 1'b1;
                end
            end
            if (!enable) begin
                m_running = 1'b0;
                m_settle  = 0;
            end else if (!m_running) begin
                m_running = 1'b1;
                m_settle  = LOCK;
            end else if (m_any_commit) begin
                m_settle = LOCK;
            end else if (m_settle > 0) begin
                m_settle = m_settle - 1;
            end
            m_e.lck = m_running && (m_settle == 0);
            m_e.rdy = 1'b1;
            for (int c = 0; c < NCLK; c++) if (m_wait[c]) m_e.rdy = 1'b0;
            exp_q.push_back(m_e);
        end
    end

    // Output monitor, sampling half a cycle after each edge.
    always @(negedge refclk) begin
        exp_t e;
        if (!rst && exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check_val("outclk",     8'(outclk),     8'(e.clk));
            check_val("outclk_stb", 8'(outclk_stb), 8'(e.stb));
            check_val("locked",     8'(locked),     8'(e.lck));
            check_val("cfg_ready",  8'(cfg_ready),  8'(e.rdy));
        end
    end

    task automatic step_cycles(input int n);
        repeat (n) begin
            @(posedge refclk);
            #1;
        end
    endtask

    task automatic check_reset();
        check_val("rst_outclk",     8'(outclk),     8'h00);
        check_val("rst_outclk_stb", 8'(outclk_stb), 8'h00);
        check_val("rst_locked",     8'(locked),     8'h00);
        check_val("rst_cfg_ready",  8'(cfg_ready),  8'h01);
    endtask

    // Holds a write until the DUT is ready, with a bounded wait.
    task automatic apply_cfg(input logic [2:0] sel, input logic [AW-1:0] incr);
        bit accepted;
        accepted  = 1'b0;
        cfg_sel   = sel;
        cfg_incr  = incr;
        cfg_valid = 1'b1;
        for (int k = 0; k < 64 && !accepted; k++) begin
            accepted = cfg_ready;
            @(posedge refclk);
            #1;
        end
        cfg_valid = 1'b0;
        check_val("cfg_accept", 8'(accepted), 8'h01);
    endtask

    function automatic logic [AW-1:0] pick_incr();
        case ($urandom_range(0, 4))
            0:       return AW'(0);
            1:       return AW'(32);
            2:       return AW'(64);
            3:       return AW'(128);
            default: return AW'($urandom_range(0, MODV - 1));
        endcase
    endfunction

    initial begin
        rst       = 1'b0;
        enable    = 1'b0;
        cfg_valid = 1'b0;
        cfg_sel   = '0;
        cfg_incr  = '0;
        #2 rst = 1'b1;
        #1 check_reset();
        @(posedge refclk);
        @(posedge refclk);
        #1 rst = 1'b0;

        // Start-up with the reset increment and lock after settling.
        step_cycles(1);
        enable = 1'b1;
        step_cycles(14 + $urandom_range(0, 3));

        // Double channel 0's frequency mid-period.
        apply_cfg(3'd0, AW'(128));
        step_cycles(12);

        // Freeze channel 1, then restart it at period eight.
        apply_cfg(3'd1, AW'(0));
        step_cycles(6);
        apply_cfg(3'd1, AW'(32));
        step_cycles(20);

        // Write to a channel that does not exist.
        apply_cfg(3'd5, AW'($urandom_range(0, MODV - 1)));
        step_cycles(8);

        // Drop enable while locked, then resume.
        enable = 1'b0;
        step_cycles(3);
        enable = 1'b1;
        step_cycles(12);

        // Randomised traffic.
        for (int n = 0; n < 300; n++) begin
            enable    = ($urandom_range(0, 15) != 0);
            cfg_valid = ($urandom_range(0, 5) == 0);
            cfg_sel   = 3'($urandom_range(0, 7));
            cfg_incr  = pick_incr();
            step_cycles(1);
        end
        cfg_valid = 1'b0;
        enable    = 1'b1;
        step_cycles(10);

        // Asynchronous reset with an update still pending.
        apply_cfg(3'd0, AW'(96));
        #2 rst = 1'b1;
        #1 check_reset();
        @(posedge refclk);
        #1 rst = 1'b0;
        step_cycles(16);

        enable = 1'b0;
        step_cycles(3);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
